// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared types for the bomb slot scheduler
package bomb_pkg;

    localparam int COORD_W = 6;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_EXPLODING = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               color;
        slot_state_t        state;
    } bomb_slot_t;

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: lifecycle FSM, fuse/blast countdown, report flag
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS  = 8,
    parameter int BLAST_TICKS = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               alloc_i,
    input  logic               tick_i,
    input  logic               report_ack_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               color_i,
    output bomb_slot_t         slot_o,
    output logic               report_pending_o
);

    localparam int FUSE_W  = $clog2(FUSE_TICKS + 1);
    localparam int BLAST_W = $clog2(BLAST_TICKS + 1);

    slot_state_t          state_q, state_d;
    logic [FUSE_W-1:0]    fuse_q, fuse_d;
    logic [BLAST_W-1:0]   blast_q, blast_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic                 color_q, color_d;
    logic                 pend_q, pend_d;

    // State and datapath registers; reset drops any live bomb and its undelivered report
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            fuse_q  <= '0;
            blast_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fuse_q  <= fuse_d;
            blast_q <= blast_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            pend_q  <= pend_d;
        end
    end

    // Next state: counters stop at 1 and the transition fires instead of wrapping
    always_comb begin
        state_d = state_q;
        fuse_d  = fuse_q;
        blast_d = blast_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        pend_d  = pend_q;
        if (report_ack_i) begin
            pend_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                // A fresh bomb ignores a coincident tick: full fuse is loaded
                if (alloc_i) begin
                    state_d = S_ARMED;
                    fuse_d  = FUSE_W'(FUSE_TICKS);
                    x_d     = x_i;
                    y_d     = y_i;
                    color_d = color_i;
                end
            end
            S_ARMED: begin
                if (tick_i) begin
                    if (fuse_q == FUSE_W'(1)) begin
                        state_d = S_EXPLODING;
                        blast_d = BLAST_W'(BLAST_TICKS);
                        pend_d  = 1'b1;
                    end else begin
                        fuse_d = fuse_q - FUSE_W'(1);
                    end
                end
            end
            S_EXPLODING: begin
                if (tick_i) begin
                    if (blast_q == BLAST_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        blast_d = blast_q - BLAST_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are straight views of the registered slot contents
    always_comb begin
        slot_o           = '{x: x_q, y: y_q, color: color_q, state: state_q};
        report_pending_o = pend_q;
    end

endmodule

// File: rtl/bomb_scheduler.sv
// rtl/bomb_scheduler.sv - shared bomb pool: drop arbitration, slot allocation, detonation reports
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int FUSE_TICKS     = 8,
    parameter int BLAST_TICKS    = 2,
    parameter int MAX_PER_PLAYER = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 tick,
    input  logic                 p0_drop,
    input  logic [COORD_W-1:0]   p0_x,
    input  logic [COORD_W-1:0]   p0_y,
    input  logic                 p1_drop,
    input  logic [COORD_W-1:0]   p1_x,
    input  logic [COORD_W-1:0]   p1_y,
    output logic                 p0_grant,
    output logic                 p0_reject,
    output logic                 p1_grant,
    output logic                 p1_reject,
    output logic                 explode_valid,
    output logic [COORD_W-1:0]   explode_x,
    output logic [COORD_W-1:0]   explode_y,
    output logic                 explode_color,
    output logic [NUM_SLOTS-1:0] slot_busy
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    bomb_slot_t           slot_info [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy, pend, alloc_vec, ack_vec, free_sel;
    logic [COORD_W-1:0]   alloc_x, alloc_y;
    logic                 alloc_color;
    logic [CNT_W-1:0]     cnt0, cnt1;
    logic                 hit0, hit1, free_any;
    logic                 elig0, elig1, win0, win1;
    logic                 rr_q, rr_d;
    logic                 g0_q, g0_d, r0_q, r0_d, g1_q, g1_d, r1_q, r1_d;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS (FUSE_TICKS),
            .BLAST_TICKS(BLAST_TICKS)
        ) u_slot (
            .clk             (clk),
            .resetn          (resetn),
            .alloc_i         (alloc_vec[i]),
            .tick_i          (tick),
            .report_ack_i    (ack_vec[i]),
            .x_i             (alloc_x),
            .y_i             (alloc_y),
            .color_i         (alloc_color),
            .slot_o          (slot_info[i]),
            .report_pending_o(pend[i])
        );
        assign busy[i] = (slot_info[i].state != S_IDLE);
    end

    assign slot_busy = busy;

    // Occupancy scan: live counts per player, cell conflicts, lowest idle slot.
    // A slot freeing this cycle is still EXPLODING, so it counts as live and is not free.
    always_comb begin
        cnt0     = '0;
        cnt1     = '0;
        hit0     = 1'b0;
        hit1     = 1'b0;
        free_any = 1'b0;
        free_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (busy[i]) begin
                if (slot_info[i].color) cnt1 = cnt1 + CNT_W'(1);
                else                    cnt0 = cnt0 + CNT_W'(1);
                if (slot_info[i].x == p0_x && slot_info[i].y == p0_y) hit0 = 1'b1;
                if (slot_info[i].x == p1_x && slot_info[i].y == p1_y) hit1 = 1'b1;
            end else if (!free_any) begin
                free_sel[i] = 1'b1;
                free_any    = 1'b1;
            end
        end
    end

    // Arbitration: rr_q names the favoured player; only a real two-way contest moves it
    always_comb begin
        elig0       = p0_drop && free_any && (cnt0 < CNT_W'(MAX_PER_PLAYER)) && !hit0;
        elig1       = p1_drop && free_any && (cnt1 < CNT_W'(MAX_PER_PLAYER)) && !hit1;
        win0        = elig0 && (!elig1 || !rr_q);
        win1        = elig1 && (!elig0 || rr_q);
        rr_d        = (elig0 && elig1) ? !rr_q : rr_q;
        g0_d        = win0;
        r0_d        = p0_drop && !win0;
        g1_d        = win1;
        r1_d        = p1_drop && !win1;
        alloc_vec   = (win0 || win1) ? free_sel : '0;
        alloc_x     = win0 ? p0_x : p1_x;
        alloc_y     = win0 ? p0_y : p1_y;
        alloc_color = win1;
    end

    // Registered grant/reject pulses and the round-robin pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= 1'b0;
            g0_q <= 1'b0;
            r0_q <= 1'b0;
            g1_q <= 1'b0;
            r1_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            g0_q <= g0_d;
            r0_q <= r0_d;
            g1_q <= g1_d;
            r1_q <= r1_d;
        end
    end

    assign p0_grant  = g0_q;
    assign p0_reject = r0_q;
    assign p1_grant  = g1_q;
    assign p1_reject = r1_q;

    // Report mux: lowest pending slot is presented and acknowledged in the same cycle
    always_comb begin
        explode_valid = 1'b0;
        explode_x     = '0;
        explode_y     = '0;
        explode_color = 1'b0;
        ack_vec       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pend[i] && !explode_valid) begin
                explode_valid = 1'b1;
                explode_x     = slot_info[i].x;
                explode_y     = slot_info[i].y;
                explode_color = slot_info[i].color;
                ack_vec[i]    = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb/tb_bomb_scheduler.sv - directed vector bench for bomb_scheduler
module tb_bomb_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tick;
    logic       p0_drop, p1_drop;
    logic [5:0] p0_x, p0_y, p1_x, p1_y;
    logic       p0_grant, p0_reject, p1_grant, p1_reject;
    logic       explode_valid, explode_color;
    logic [5:0] explode_x, explode_y;
    logic [3:0] slot_busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int tk; int d0; int x0; int y0; int d1; int x1; int y1;
        int g0; int r0; int g1; int r1; int ev; int ex; int ey; int ec; int busy;
    } vec_t;

    vec_t tbl[$];

    bomb_scheduler #(
        .NUM_SLOTS(4), .FUSE_TICKS(8), .BLAST_TICKS(2), .MAX_PER_PLAYER(2)
    ) dut (
        .clk(clk), .resetn(resetn), .tick(tick),
        .p0_drop(p0_drop), .p0_x(p0_x), .p0_y(p0_y),
        .p1_drop(p1_drop), .p1_x(p1_x), .p1_y(p1_y),
        .p0_grant(p0_grant), .p0_reject(p0_reject),
        .p1_grant(p1_grant), .p1_reject(p1_reject),
        .explode_valid(explode_valid), .explode_x(explode_x),
        .explode_y(explode_y), .explode_color(explode_color),
        .slot_busy(slot_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int tk, int d0, int x0, int y0, int d1, int x1, int y1,
                                int g0, int r0, int g1, int r1,
                                int ev, int ex, int ey, int ec, int busy);
        vec_t v;
        v = '{tk, d0, x0, y0, d1, x1, y1, g0, r0, g1, r1, ev, ex, ey, ec, busy};
        return v;
    endfunction

    task automatic check_out(input string name, input vec_t v);
        logic [21:0] got, want;
        got  = {p0_grant, p0_reject, p1_grant, p1_reject, explode_valid,
                explode_x, explode_y, explode_color, slot_busy};
        want = {v.g0[0], v.r0[0], v.g1[0], v.r1[0], v.ev[0],
                v.ex[5:0], v.ey[5:0], v.ec[0], v.busy[3:0]};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got g0r0g1r1=%b ev=%b xy=(%0d,%0d) c=%b busy=%b, want g0r0g1r1=%b ev=%b xy=(%0d,%0d) c=%b busy=%b",
                     name, got[21:18], got[17], got[16:11], got[10:5], got[4], got[3:0],
                     want[21:18], want[17], want[16:11], want[10:5], want[4], want[3:0]);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        tick    = v.tk[0];
        p0_drop = v.d0[0];
        p0_x    = v.x0[5:0];
        p0_y    = v.y0[5:0];
        p1_drop = v.d1[0];
        p1_x    = v.x1[5:0];
        p1_y    = v.y1[5:0];
        @(negedge clk);
        check_out(name, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // tk d0 x0 y0 d1 x1 y1 | g0 r0 g1 r1 ev ex ey ec busy
        tbl.push_back(mk(0,1,1,1,1,2,2, 1,0,0,1, 0,0,0,0,4'b0001)); // contest, rr->p0
        tbl.push_back(mk(0,1,1,2,1,2,2, 0,1,1,0, 0,0,0,0,4'b0011)); // contest, rr->p1
        tbl.push_back(mk(0,1,1,1,1,2,2, 0,1,0,1, 0,0,0,0,4'b0011)); // both on own live cells
        tbl.push_back(mk(0,1,3,3,0,0,0, 1,0,0,0, 0,0,0,0,4'b0111)); // p0 second bomb
        tbl.push_back(mk(0,1,4,4,0,0,0, 0,1,0,0, 0,0,0,0,4'b0111)); // p0 third -> limit
        tbl.push_back(mk(0,0,0,0,1,1,1, 0,0,0,1, 0,0,0,0,4'b0111)); // p1 on p0's cell
        tbl.push_back(mk(0,0,0,0,1,5,5, 0,0,1,0, 0,0,0,0,4'b1111)); // pool now full
        tbl.push_back(mk(0,0,0,0,1,6,6, 0,0,0,1, 0,0,0,0,4'b1111)); // 5th drop
        tbl.push_back(mk(0,1,6,6,0,0,0, 0,1,0,0, 0,0,0,0,4'b1111));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b1111));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 1,1,1,0,4'b1111)); // 8th tick: burst
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,2,2,1,4'b1111));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,3,3,0,4'b1111));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,5,5,1,4'b1111));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b1111));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b1111)); // blast 2->1
        tbl.push_back(mk(1,1,7,7,0,0,0, 0,1,0,0, 0,0,0,0,4'b0000)); // freeing cycle, full
        tbl.push_back(mk(1,1,7,7,0,0,0, 1,0,0,0, 0,0,0,0,4'b0001)); // retry on a tick
        tbl.push_back(mk(0,1,9,9,1,9,9, 1,0,0,1, 0,0,0,0,4'b0011)); // same cell contest
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0011));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 1,7,7,0,4'b0011)); // full fuse honoured
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 1,9,9,0,4'b0011)); // pending survives tick
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0000));

        resetn = 1'b0;
        tick = 1'b0; p0_drop = 1'b0; p1_drop = 1'b0;
        p0_x = '0; p0_y = '0; p1_x = '0; p1_y = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check_out("reset state", mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));

        // Reset in the middle of a fuse
        run_vec("pre-reset drop", mk(0,1,5,5,0,0,0, 1,0,0,0, 0,0,0,0,4'b0001));
        for (int i = 0; i < 3; i++)
            run_vec("pre-reset tick", mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0001));
        tick = 1'b0;
        resetn = 1'b0;
        #1;
        check_out("async reset", mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++)
            run_vec("post-reset quiet", mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0000));

        // Single drop lifecycle
        run_vec("single drop", mk(0,1,3,4,0,0,0, 1,0,0,0, 0,0,0,0,4'b0001));
        for (int i = 0; i < 7; i++)
            run_vec("fuse running", mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0001));
        run_vec("detonation", mk(1,0,0,0,0,0,0, 0,0,0,0, 1,3,4,0,4'b0001));
        run_vec("report once", mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0001));
        run_vec("blast tick 1", mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0001));
        run_vec("blast tick 2", mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,4'b0000));

        foreach (tbl[i])
            run_vec($sformatf("tbl[%0d]", i), tbl[i]);

        tick = 1'b0; p0_drop = 1'b0; p1_drop = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
